// File: rtl/microseq_ctrl_if.sv
// rtl/microseq_ctrl_if.sv - sequencer <-> IR/memory/datapath signal bundle
// Optional MICROSEQ_HALT_EN adds the halted status line.
interface microseq_ctrl_if #(
  parameter int INSTR_W = 14,
  parameter int REG_AW  = 2,
  parameter int IMM_W   = INSTR_W - 4 - 2*REG_AW,
  parameter int COUNT_W = 16
);
  logic               run;
  logic [INSTR_W-1:0] instruction;
  logic               mem_ready;
  logic               alu_zero;
  logic               alu_neg;
  logic [1:0]         data_bus_sel;
  logic [REG_AW-1:0]  reg_address;
  logic               pc_load_en;
  logic               pc_inc_en;
  logic               ir_load_en;
  logic               rf_write_en;
  logic               alu_src1_load_en;
  logic               alu_src2_load_en;
  logic [2:0]         alu_op;
  logic               mem_req;
  logic [IMM_W-1:0]   imm_out;
  logic               illegal;
  logic [COUNT_W-1:0] instr_count;
`ifdef MICROSEQ_HALT_EN
  logic               halted;
`endif

  modport master (
    input  run, instruction, mem_ready, alu_zero, alu_neg,
    output data_bus_sel, reg_address, pc_load_en, pc_inc_en, ir_load_en,
           rf_write_en, alu_src1_load_en, alu_src2_load_en, alu_op, mem_req,
           imm_out, illegal, instr_count
`ifdef MICROSEQ_HALT_EN
    , output halted
`endif
  );

  modport slave (
    output run, instruction, mem_ready, alu_zero, alu_neg,
    input  data_bus_sel, reg_address, pc_load_en, pc_inc_en, ir_load_en,
           rf_write_en, alu_src1_load_en, alu_src2_load_en, alu_op, mem_req,
           imm_out, illegal, instr_count
`ifdef MICROSEQ_HALT_EN
    , input halted
`endif
  );
endinterface

// File: rtl/microseq_ctrl.sv
// rtl/microseq_ctrl.sv - multicycle fetch/decode/execute control sequencer
// Define MICROSEQ_HALT_EN to decode opcode 15 as HALT.
module microseq_ctrl #(
  parameter int INSTR_W = 14,
  parameter int REG_AW  = 2,
  parameter int IMM_W   = INSTR_W - 4 - 2*REG_AW,
  parameter int COUNT_W = 16
) (
  input logic           clock,
  input logic           reset,
  microseq_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SRC1, S_SRC2, S_EXEC, S_HALTED
  } state_t;

  localparam logic [1:0] BUS_PC  = 2'd0;
  localparam logic [1:0] BUS_RF  = 2'd1;
  localparam logic [1:0] BUS_ALU = 2'd2;
  localparam logic [1:0] BUS_IMM = 2'd3;

  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_BGE  = 4'd7;
  localparam logic [3:0] OP_BLT  = 4'd8;
  localparam logic [3:0] OP_BNE  = 4'd9;

  state_t             state_q, state_d;
  logic [3:0]         opc_q;
  logic [REG_AW-1:0]  rd_q, rs1_q, rs2_q;
  logic [IMM_W-1:0]   imm_q;
  logic [COUNT_W-1:0] count_q;

  logic [3:0]         opc_in;
  logic               dec_halt, dec_illegal;
  logic               is_branch, taken;

  assign opc_in = bus.instruction[INSTR_W-1 -: 4];

`ifdef MICROSEQ_HALT_EN
  assign dec_halt = (opc_in == 4'd15);
`else
  assign dec_halt = 1'b0;
`endif
  assign dec_illegal = (opc_in > OP_BNE) && !dec_halt;
  assign is_branch   = (opc_q >= OP_BEQ) && (opc_q <= OP_BNE);

  always_comb begin
    taken = 1'b0;
    case (opc_q)
      OP_BEQ:  taken = bus.alu_zero;
      OP_BNE:  taken = !bus.alu_zero;
      OP_BLT:  taken = bus.alu_neg;
      OP_BGE:  taken = !bus.alu_neg;
      default: taken = 1'b0;
    endcase
  end

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      4'd1:    alu_code = 3'd1;
      4'd3:    alu_code = 3'd2;
      4'd4:    alu_code = 3'd3;
      4'd5:    alu_code = 3'd4;
      default: alu_code = 3'd0;
    endcase
  endfunction

  // State register, decoded field latches and retired-instruction counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        opc_q <= opc_in;
        rd_q  <= bus.instruction[INSTR_W-5 -: REG_AW];
        rs1_q <= bus.instruction[INSTR_W-5-REG_AW -: REG_AW];
        rs2_q <= bus.instruction[INSTR_W-5-2*REG_AW -: REG_AW];
        imm_q <= bus.instruction[IMM_W-1:0];
      end
      if ((state_q == S_EXEC) ||
          ((state_q == S_DECODE) && (dec_illegal || dec_halt)))
        count_q <= count_q + COUNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.run) state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (dec_halt)         state_d = S_HALTED;
        else if (dec_illegal) state_d = S_FETCH;
        else                  state_d = S_SRC1;
      end
      S_SRC1:   state_d = S_SRC2;
      S_SRC2:   state_d = S_EXEC;
      S_EXEC:   state_d = S_FETCH;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.data_bus_sel     = BUS_PC;
    bus.reg_address      = '0;
    bus.pc_load_en       = 1'b0;
    bus.pc_inc_en        = 1'b0;
    bus.ir_load_en       = 1'b0;
    bus.rf_write_en      = 1'b0;
    bus.alu_src1_load_en = 1'b0;
    bus.alu_src2_load_en = 1'b0;
    bus.alu_op           = 3'd0;
    bus.mem_req          = 1'b0;
    bus.illegal          = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_req    = 1'b1;
        bus.ir_load_en = bus.mem_ready;
        bus.pc_inc_en  = bus.mem_ready;
      end
      S_DECODE: bus.illegal = dec_illegal;
      S_SRC1: begin
        bus.data_bus_sel     = BUS_RF;
        bus.reg_address      = is_branch ? rd_q : rs1_q;
        bus.alu_src1_load_en = 1'b1;
      end
      S_SRC2: begin
        bus.alu_src2_load_en = 1'b1;
        if (opc_q == OP_ADDI) begin
          bus.data_bus_sel = BUS_IMM;
        end else begin
          bus.data_bus_sel = BUS_RF;
          bus.reg_address  = is_branch ? rs1_q : rs2_q;
        end
      end
      S_EXEC: begin
        // Branches compare by subtraction; target is the absolute immediate
        if (is_branch) begin
          bus.alu_op = 3'd1;
          if (taken) begin
            bus.data_bus_sel = BUS_IMM;
            bus.pc_load_en   = 1'b1;
          end
        end else begin
          bus.alu_op       = alu_code(opc_q);
          bus.data_bus_sel = BUS_ALU;
          bus.reg_address  = rd_q;
          bus.rf_write_en  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.imm_out     = imm_q;
  assign bus.instr_count = count_q;
`ifdef MICROSEQ_HALT_EN
  assign bus.halted = (state_q == S_HALTED);
`endif
endmodule

// File: tb/tb_microseq_ctrl.sv
// tb/tb_microseq_ctrl.sv - directed scoreboard bench for microseq_ctrl
// Covers both builds of MICROSEQ_HALT_EN.
module tb_microseq_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  microseq_ctrl_if u ();
  microseq_ctrl dut (.clock(clock), .reset(reset), .bus(u));

  localparam logic [7:0] PCL = 8'h80, PCI = 8'h40, IRL = 8'h20, RFW = 8'h10;
  localparam logic [7:0] S1  = 8'h08, S2  = 8'h04, MRQ = 8'h02, ILL = 8'h01;

  typedef struct {
    string       tag;
    logic        rst, run, mr, z, n, hlt;
    logic [13:0] ins;
    logic [36:0] exp;
  } ent_t;

  ent_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic        g_rst, g_run, eh;
  logic [13:0] cur_ins;
  logic [5:0]  ei;
  logic [15:0] ec;

  task automatic push(input string tag, input logic mr, z, n,
                      input logic [1:0] bus_sel, addr, input logic [2:0] op,
                      input logic [7:0] en);
    ent_t e;
    e.tag = tag; e.rst = g_rst; e.run = g_run; e.ins = cur_ins;
    e.mr = mr; e.z = z; e.n = n; e.hlt = eh;
    e.exp = {bus_sel, addr, op, en, ei, ec};
    sb.push_back(e);
  endtask

  task automatic fetch_rdy(input string tag);
    push(tag, 1, 0, 0, 0, 0, 0, MRQ | IRL | PCI);
  endtask

  task automatic drain();
    ent_t        e;
    logic [36:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; u.run = e.run; u.instruction = e.ins;
      u.mem_ready = e.mr; u.alu_zero = e.z; u.alu_neg = e.n;
      @(negedge clock);
      obs = {u.data_bus_sel, u.reg_address, u.alu_op, u.pc_load_en,
             u.pc_inc_en, u.ir_load_en, u.rf_write_en, u.alu_src1_load_en,
             u.alu_src2_load_en, u.mem_req, u.illegal, u.imm_out,
             u.instr_count};
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
`ifdef MICROSEQ_HALT_EN
      checks++;
      assert (u.halted === e.hlt) else begin
        failures++;
        $error("FAIL %s_halted observed=%b expected=%b", e.tag, u.halted, e.hlt);
      end
`endif
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    u.run = 1'b0; u.instruction = '0; u.mem_ready = 1'b0;
    u.alu_zero = 1'b0; u.alu_neg = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    g_rst = 0; g_run = 0; eh = 0; cur_ins = '0; ei = '0; ec = '0;

    push("reset_idle", 0, 0, 0, 0, 0, 0, 0);
    g_run = 1;
    push("idle_run", 0, 0, 0, 0, 0, 0, 0);

    // ADD rd=3 rs1=1 rs2=2 behind three wait states
    cur_ins = 14'h0360;
    for (int i = 0; i < 3; i++) push("fetch_wait", 0, 0, 0, 0, 0, 0, MRQ);
    fetch_rdy("fetch_ready");
    push("add_decode", 0, 0, 0, 0, 0, 0, 0);
    ei = 6'h20;
    push("add_src1", 0, 0, 0, 1, 1, 0, S1);
    push("add_src2", 0, 0, 0, 1, 2, 0, S2);
    push("add_exec", 0, 0, 0, 2, 3, 0, RFW);
    ec = 1;

    // ADDI rd=2 rs1=1 imm=2A with run dropped mid-instruction
    g_run = 0; cur_ins = 14'h0A6A;
    fetch_rdy("addi_fetch");
    push("addi_decode", 0, 0, 0, 0, 0, 0, 0);
    ei = 6'h2A;
    push("addi_src1", 0, 0, 0, 1, 1, 0, S1);
    push("addi_src2", 0, 0, 0, 3, 0, 0, S2);
    push("addi_exec", 0, 0, 0, 2, 2, 0, RFW);
    ec = 2; g_run = 1;

    // OR rd=1 rs1=2 rs2=3
    cur_ins = 14'h15B0;
    fetch_rdy("or_fetch");
    push("or_decode", 0, 0, 0, 0, 0, 0, 0);
    ei = 6'h30;
    push("or_src1", 0, 0, 0, 1, 2, 0, S1);
    push("or_src2", 0, 0, 0, 1, 3, 0, S2);
    push("or_exec", 0, 0, 0, 2, 1, 4, RFW);
    ec = 3;

    // BEQ rd=1 rs1=2 target 15, zero set -> taken
    cur_ins = 14'h1995;
    fetch_rdy("beq_fetch");
    push("beq_decode", 0, 0, 0, 0, 0, 0, 0);
    ei = 6'h15;
    push("beq_src1", 0, 0, 0, 1, 1, 0, S1);
    push("beq_src2", 0, 0, 0, 1, 2, 0, S2);
    push("beq_exec", 0, 1, 0, 3, 0, 1, PCL);
    ec = 4;

    // BNE with zero set -> not taken
    cur_ins = 14'h2595;
    fetch_rdy("bne_fetch");
    push("bne_decode", 0, 0, 0, 0, 0, 0, 0);
    push("bne_src1", 0, 0, 0, 1, 1, 0, S1);
    push("bne_src2", 0, 0, 0, 1, 2, 0, S2);
    push("bne_exec", 0, 1, 0, 0, 0, 1, 0);
    ec = 5;

    // BLT with neg set -> taken
    cur_ins = 14'h2195;
    fetch_rdy("blt_fetch");
    push("blt_decode", 0, 0, 0, 0, 0, 0, 0);
    push("blt_src1", 0, 0, 0, 1, 1, 0, S1);
    push("blt_src2", 0, 0, 0, 1, 2, 0, S2);
    push("blt_exec", 0, 0, 1, 3, 0, 1, PCL);
    ec = 6;

    // BGE with neg set -> not taken
    cur_ins = 14'h1D95;
    fetch_rdy("bge_fetch");
    push("bge_decode", 0, 0, 0, 0, 0, 0, 0);
    push("bge_src1", 0, 0, 0, 1, 1, 0, S1);
    push("bge_src2", 0, 0, 0, 1, 2, 0, S2);
    push("bge_exec", 0, 0, 1, 0, 0, 1, 0);
    ec = 7;

    // Opcode 12 is undefined
    cur_ins = 14'h3000;
    fetch_rdy("ill_fetch");
    push("ill_decode", 0, 0, 0, 0, 0, 0, ILL);
    ec = 8; ei = 6'h00;
    push("ill_next_fetch", 0, 0, 0, 0, 0, 0, MRQ);

    // Reset while in SRC2 of an ADD
    cur_ins = 14'h0360;
    fetch_rdy("rst_fetch");
    push("rst_decode", 0, 0, 0, 0, 0, 0, 0);
    ei = 6'h20;
    push("rst_src1", 0, 0, 0, 1, 1, 0, S1);
    g_rst = 1;
    push("rst_src2", 0, 0, 0, 1, 2, 0, S2);
    g_rst = 0; g_run = 0; ec = 0; ei = 0;
    push("rst_idle", 0, 0, 0, 0, 0, 0, 0);
    g_run = 1;
    push("rst_idle_run", 0, 0, 0, 0, 0, 0, 0);
    push("restart_fetch", 0, 0, 0, 0, 0, 0, MRQ);

    // Opcode 15
    cur_ins = 14'h3C00;
    fetch_rdy("op15_fetch");
`ifdef MICROSEQ_HALT_EN
    push("halt_decode", 0, 0, 0, 0, 0, 0, 0);
    ec = 1; eh = 1;
    for (int i = 0; i < 20; i++) push("halt_hold", 1, 0, 0, 0, 0, 0, 0);
`else
    push("op15_decode", 0, 0, 0, 0, 0, 0, ILL);
    ec = 1;
    push("op15_next_fetch", 0, 0, 0, 0, 0, 0, MRQ);
`endif

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
